// File: rtl/qupls_decode_out_queue.sv
// Decode-output FIFO: holds decoded instruction, precision code and PC
// between the decoders and rename, with flush and registered-only in_ready.
module qupls_decode_out_queue #(
  parameter int DEPTH = 4,
  parameter int IW    = 64,
  parameter int PW    = 3,
  parameter int PCW   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IW-1:0]            in_instr,
  input  logic [PW-1:0]            in_prec,
  input  logic [PCW-1:0]           in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IW-1:0]            out_instr,
  output logic [PW-1:0]            out_prec,
  output logic [PCW-1:0]           out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [IW-1:0]  instr_mem [DEPTH];
  logic [PW-1:0]  prec_mem  [DEPTH];
  logic [PCW-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           enq;
  logic           deq;

  // in_ready looks only at registered occupancy, so a full queue stays closed
  // even when rename drains the head in the same cycle.
  assign in_ready  = !rst && (count != FULL);
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  assign out_instr = instr_mem[rd_ptr];
  assign out_prec  = prec_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        prec_mem[i]  <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        instr_mem[wr_ptr] <= in_instr;
        prec_mem[wr_ptr]  <= in_prec;
        pc_mem[wr_ptr]    <= in_pc;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_qupls_decode_out_queue.sv
// Scoreboard bench for qupls_decode_out_queue: directed scenarios followed by
// a random stream with flushes, every output checked against a queue model.
module tb_qupls_decode_out_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] instr;
    logic [2:0]  prec;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [63:0] in_instr, out_instr;
  logic [2:0]  in_prec, out_prec;
  logic [31:0] in_pc, out_pc;
  logic [2:0]  count;

  ent_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic last_enq;

  qupls_decode_out_queue #(.DEPTH(DEPTH), .IW(64), .PW(3), .PCW(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_prec(in_prec), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_prec(out_prec), .out_pc(out_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Check outputs against the model, then advance one edge and update the model.
  task automatic cycle();
    logic e, d;
    ent_t cur;
    #1;
    check("in_ready", in_ready, 64'(!rst && sb.size() != DEPTH));
    check("out_valid", out_valid, 64'(sb.size() != 0));
    check("count", count, 64'(sb.size()));
    check("count_bound", 64'(count <= 3'(DEPTH)), 64'd1);
    if (sb.size() != 0) begin
      check("out_instr", out_instr, sb[0].instr);
      check("out_prec", out_prec, 64'(sb[0].prec));
      check("out_pc", out_pc, 64'(sb[0].pc));
    end
    e   = in_valid && !rst && (sb.size() != DEPTH);
    d   = (sb.size() != 0) && out_ready;
    cur = '{instr: in_instr, prec: in_prec, pc: in_pc};
    @(posedge clk);
    if (rst || flush) begin
      sb.delete();
      last_enq = 1'b0;
    end else begin
      if (d) void'(sb.pop_front());
      if (e) sb.push_back(cur);
      last_enq = e;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] instr, input logic [2:0] prec, input logic [31:0] pc);
    int n;
    in_valid = 1'b1;
    in_instr = instr;
    in_prec  = prec;
    in_pc    = pc;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_enq && n < 50);
    if (!last_enq) check("send_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_prec = '0; in_pc = '0; last_enq = 1'b0;

    // 1: reset, single entry, single dequeue
    @(posedge clk); @(negedge clk);
    cycle();
    rst = 1'b0;
    #1;
    check("rst_instr", out_instr, 64'd0);
    check("rst_prec", out_prec, 64'd0);
    check("rst_pc", out_pc, 64'd0);
    send(64'h0000_1234_5678_9ABC, 3'd4, 32'h0000_1000);
    in_valid = 1'b0;
    #1;
    check("t1_valid", out_valid, 64'd1);
    check("t1_instr", out_instr, 64'h0000_1234_5678_9ABC);
    check("t1_prec", out_prec, 64'd4);
    check("t1_pc", out_pc, 64'h1000);
    check("t1_count", count, 64'd1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    #1;
    check("t1_empty", out_valid, 64'd0);
    check("t1_count0", count, 64'd0);

    // 2: fill and stall, fifth entry held by the source
    for (int i = 0; i < 4; i++) send(64'(i + 16'hA0), 3'(i), 32'h100 + 32'(4 * i));
    in_instr = 64'hA4; in_prec = 3'd7; in_pc = 32'h110;
    #1;
    check("t2_full_ready", in_ready, 64'd0);
    check("t2_full_count", count, 64'd4);
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 1'b1;
    send(64'hA4, 3'd7, 32'h110);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    out_ready = 1'b0;

    // 3: full, then streaming through pointer wrap
    for (int i = 0; i < 4; i++) send(64'(i + 16'hB0), 3'(i + 1), 32'h300 + 32'(4 * i));
    out_ready = 1'b1;
    #1;
    check("t3_count4", count, 64'd4);
    for (int i = 4; i < 14; i++) send(64'(i + 16'hB0), 3'(i + 1), 32'h300 + 32'(4 * i));
    #1;
    check("t3_steady", count, 64'd3);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    out_ready = 1'b0;

    // 4: flush discards queue and same-cycle handshakes
    for (int i = 0; i < 3; i++) send(64'(i + 16'hC0), 3'(i), 32'h180 + 32'(4 * i));
    in_instr = 64'hDEAD; in_pc = 32'h1FC; out_ready = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    #1;
    check("t4_valid", out_valid, 64'd0);
    check("t4_count", count, 64'd0);
    check("t4_ready", in_ready, 64'd1);
    send(64'h200_0000, 3'd2, 32'h200);
    in_valid = 1'b0;
    #1;
    check("t4_first_pc", out_pc, 64'h200);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // 5: mid-stream reset
    send(64'hE0, 3'd1, 32'h400);
    send(64'hE1, 3'd2, 32'h404);
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("t5_valid", out_valid, 64'd0);
    check("t5_count", count, 64'd0);
    check("t5_instr", out_instr, 64'd0);
    check("t5_prec", out_prec, 64'd0);
    check("t5_pc", out_pc, 64'd0);

    // 6: random stress with occasional flush
    for (int i = 0; i < 10000; i++) begin
      if (!(in_valid && !last_enq)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_instr = {$urandom(), $urandom()};
        in_prec  = 3'($urandom_range(0, 7));
        in_pc    = $urandom();
      end
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 199) == 0);
      cycle();
      if (flush) last_enq = 1'b0;
      flush = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
